// File: rtl/reg_16.sv
// reg_16: WIDTH-bit storage register with a load enable and an
// asynchronous active-low reset. The output comes straight from the flops,
// so there is no combinational path from in or load to out.
//
// Handshake: there is no valid/ready pair. load acts as a one-cycle write
// strobe. When load is sampled high at a rising clk edge, in is captured.
// When load is sampled low at that edge, the stored value is kept.
module reg_16 #(
  parameter int              WIDTH       = 16,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic [WIDTH-1:0] in,
  input  logic             load,
  input  logic             clk,
  output logic [WIDTH-1:0] out,
  input  logic             rst_n
);

  logic [WIDTH-1:0] out_q;
  logic [WIDTH-1:0] out_d;

  // Next value: capture all bits of in together when loading, otherwise hold.
  always_comb begin
    out_d = out_q;
    if (load) begin
      out_d = in;
    end
  end

  // Storage flops. Reset is asynchronous and wins over load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q <= RESET_VALUE;
    end else begin
      out_q <= out_d;
    end
  end

  assign out = out_q;

endmodule

// File: tb/tb_reg_16.sv
// tb_reg_16: randomized and directed stimulus for reg_16. The reference is a
// single stored word that is updated from the register's rules.
module tb_reg_16;

  localparam int W = 16;

  // Clock and reset
  logic         clk;
  logic         rst_n;
  logic [W-1:0] in;
  logic         load;
  logic [W-1:0] out;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  reg_16 #(.WIDTH(W), .RESET_VALUE('0)) dut (
    .in    (in),
    .load  (load),
    .clk   (clk),
    .out   (out),
    .rst_n (rst_n)
  );

  // Scoreboard state
  logic [W-1:0] exp_q[$];
  logic [W-1:0] model;
  int           n_checks;
  int           n_pass;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: out=%h expected=%h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Drive one clock cycle. Inputs are applied at the falling edge, and the
  // result is checked just after the rising edge. Afterwards in and load are
  // disturbed to confirm that out ignores changes between edges.
  task automatic cycle(input logic ld, input logic [W-1:0] d);
    @(negedge clk);
    load = ld;
    in   = d;
    #1;
    check("fall_edge_hold", out, model);
    #3;
    check("pre_rise_hold", out, model);
    @(posedge clk);
    if (rst_n && ld) model = d;
    exp_q.push_back(model);
    #1;
    check("post_rise", out, exp_q.pop_front());
    in   = W'($urandom);
    load = 1'($urandom);
    #1;
    check("between_edges", out, model);
  endtask

  // Assert reset between edges and hold it across a rising edge while
  // load=1 and in=d. Release it at a falling edge with load=0.
  task automatic mid_reset(input logic [W-1:0] d);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    model = '0;
    #1;
    check("async_reset", out, model);
    load = 1'b1;
    in   = d;
    @(posedge clk);
    #1;
    check("reset_over_load", out, model);
    @(negedge clk);
    load  = 1'b0;
    rst_n = 1'b1;
    #1;
    check("reset_release", out, model);
    @(posedge clk);
    #1;
    check("hold_after_release", out, model);
  endtask

  // Directed cases followed by random traffic, then the report.
  initial begin
    n_checks = 0;
    n_pass   = 0;
    model    = '0;
    rst_n    = 1'b0;
    load     = 1'b0;
    in       = '0;
    #1;
    check("reset_state", out, model);
    repeat (2) @(posedge clk);
    #1;
    check("reset_held", out, model);
    @(negedge clk);
    rst_n = 1'b1;

    // Idle after reset.
    for (int i = 0; i < 3; i++) cycle(1'b0, W'($urandom));
    // Load zero, then hold.
    cycle(1'b1, 16'h0000);
    cycle(1'b0, 16'h0000);
    // Load all ones, then hold while in changes.
    cycle(1'b1, 16'hFFFF);
    cycle(1'b0, 16'h0000);
    cycle(1'b0, 16'h1234);
    // Reset mid-operation with a concurrent load, then load A5A5.
    mid_reset(16'hA5A5);
    cycle(1'b1, 16'hA5A5);
    // Load a value equal to the stored value.
    cycle(1'b1, 16'hA5A5);
    cycle(1'b1, 16'h5A5A);

    // Random traffic.
    for (int i = 0; i < 150; i++) begin
      logic [W-1:0] d;
      int sel;
      sel = int'($urandom_range(0, 9));
      case (sel)
        0:       d = '0;
        1:       d = '1;
        default: d = W'($urandom);
      endcase
      if ($urandom_range(0, 19) == 0) begin
        mid_reset(d);
      end else begin
        cycle(1'($urandom_range(0, 2) != 0), d);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
